// File: rtl/gnrl_pipe_stages_if.sv
// Valid/ready/data bundle for one side of a gnrl_pipe_stages boundary.
interface gnrl_pipe_stages_if #(
  parameter int DW = 32
);
  logic          valid;
  logic          ready;
  logic [DW-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/gnrl_pipe_stages.sv
// Elastic pipe of DEPTH 2-entry skid stages; DEPTH-edge latency, registered in_ready, 1 item/cycle.
// GNRL_PIPE_XCHECK_EN adds simulation-only X and stall-stability checks (dropped under FPGA_SOURCE).
module gnrl_pipe_stages #(
  parameter int            DW      = 32,
  parameter int            DEPTH   = 1,
  parameter logic [DW-1:0] RST_VAL = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  gnrl_pipe_stages_if.slave  in_if,
  gnrl_pipe_stages_if.master out_if,
  output logic               busy
);

  generate
    if (DEPTH == 0) begin : g_bypass
      assign out_if.valid = in_if.valid;
      assign out_if.data  = in_if.data;
      assign in_if.ready  = out_if.ready;
      assign busy         = 1'b0;
    end else begin : g_pipe
      logic [DEPTH-1:0] m_vld_q;
      logic [DEPTH-1:0] s_vld_q;
      logic [DW-1:0]    m_dat_q [DEPTH];

      for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic          up_vld;
        logic [DW-1:0] up_dat;
        logic          dn_rdy;
        logic          m_vld;
        logic          s_vld;
        logic [DW-1:0] m_dat;
        logic [DW-1:0] s_dat;
        logic          in_fire;
        logic          out_fire;

        if (k == 0) begin : g_first
          assign up_vld = in_if.valid;
          assign up_dat = in_if.data;
        end else begin : g_chain
          assign up_vld = m_vld_q[k-1];
          assign up_dat = m_dat_q[k-1];
        end

        // Downstream ready is always a register (next stage's !s_vld or the sink).
        if (k == DEPTH - 1) begin : g_last
          assign dn_rdy = out_if.ready;
        end else begin : g_inner
          assign dn_rdy = ~s_vld_q[k+1];
        end

        assign in_fire  = up_vld & ~s_vld;
        assign out_fire = m_vld & dn_rdy;

        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            m_vld <= 1'b0;
            s_vld <= 1'b0;
            m_dat <= RST_VAL;
            s_dat <= RST_VAL;
          end else if (flush) begin
            m_vld <= 1'b0;
            s_vld <= 1'b0;
          end else if (!m_vld || out_fire) begin
            if (s_vld) begin
              m_vld <= 1'b1;
              m_dat <= s_dat;
              s_vld <= in_fire;
              if (in_fire) s_dat <= up_dat;
            end else begin
              m_vld <= in_fire;
              if (in_fire) m_dat <= up_dat;
            end
          end else if (in_fire) begin
            s_vld <= 1'b1;
            s_dat <= up_dat;
          end
        end

        assign m_vld_q[k] = m_vld;
        assign s_vld_q[k] = s_vld;
        assign m_dat_q[k] = m_dat;
      end

      assign in_if.ready  = ~s_vld_q[0];
      assign out_if.valid = m_vld_q[DEPTH-1];
      assign out_if.data  = m_dat_q[DEPTH-1];
      assign busy         = (|m_vld_q) | (|s_vld_q);
    end
  endgenerate

`ifdef GNRL_PIPE_XCHECK_EN
`ifndef FPGA_SOURCE
  always @(posedge clk) begin
    if (!rst) begin
      if ($isunknown({in_if.valid, out_if.ready, flush}))
        $fatal(1, "%m: X on in_valid/out_ready/flush");
      if (in_if.valid && $isunknown(in_if.data))
        $fatal(1, "%m: X on in_data while in_valid");
    end
  end

  assert property (@(posedge clk) disable iff (rst)
    (in_if.valid && !in_if.ready) |=> $stable(in_if.data))
    else $fatal(1, "%m: in_data changed while stalled");
`endif
`endif

endmodule

// File: tb/tb_gnrl_pipe_stages.sv
// Bench: lane 0 = DEPTH 3 / RST_VAL DEADBEEF, lane 1 = DEPTH 2, plus a DEPTH 0 instance.
module tb_gnrl_pipe_stages;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]  in_vld, out_rdy, flush;
  logic [31:0] in_dat [2];
  logic [1:0]  in_rdy, out_vld, busy;
  logic [31:0] out_dat [2];
  logic        z_flush, z_busy;

  int n_vec = 0;
  int n_err = 0;

  gnrl_pipe_stages_if #(.DW(32)) a_in ();
  gnrl_pipe_stages_if #(.DW(32)) a_out ();
  gnrl_pipe_stages_if #(.DW(32)) b_in ();
  gnrl_pipe_stages_if #(.DW(32)) b_out ();
  gnrl_pipe_stages_if #(.DW(32)) z_in ();
  gnrl_pipe_stages_if #(.DW(32)) z_out ();

  assign a_in.valid  = in_vld[0];
  assign a_in.data   = in_dat[0];
  assign a_out.ready = out_rdy[0];
  assign in_rdy[0]   = a_in.ready;
  assign out_vld[0]  = a_out.valid;
  assign out_dat[0]  = a_out.data;
  assign b_in.valid  = in_vld[1];
  assign b_in.data   = in_dat[1];
  assign b_out.ready = out_rdy[1];
  assign in_rdy[1]   = b_in.ready;
  assign out_vld[1]  = b_out.valid;
  assign out_dat[1]  = b_out.data;

  gnrl_pipe_stages #(.DW(32), .DEPTH(3), .RST_VAL(32'hDEAD_BEEF)) u_d3 (
    .clk(clk), .rst(rst), .flush(flush[0]), .in_if(a_in), .out_if(a_out), .busy(busy[0]));
  gnrl_pipe_stages #(.DW(32), .DEPTH(2)) u_d2 (
    .clk(clk), .rst(rst), .flush(flush[1]), .in_if(b_in), .out_if(b_out), .busy(busy[1]));
  gnrl_pipe_stages #(.DW(32), .DEPTH(0)) u_d0 (
    .clk(clk), .rst(rst), .flush(z_flush), .in_if(z_in), .out_if(z_out), .busy(z_busy));

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: a pipe is an ordered store of at most 2*DEPTH items.
  for (genvar g = 0; g < 2; g++) begin : g_chk
    localparam int D = (g == 0) ? 3 : 2;
    logic [31:0] q [$];
    int popped = 0;
    always @(negedge clk) begin
      if (rst) begin
        q.delete();
      end else begin
        check($sformatf("l%0d busy", g), busy[g], q.size() != 0);
        if (q.size() == 2 * D) check($sformatf("l%0d full in_rdy", g), in_rdy[g], 1'b0);
        if (out_vld[g])
          check($sformatf("l%0d out_dat", g), out_dat[g], (q.size() != 0) ? q[0] : 32'hxxxx_xxxx);
        if (out_vld[g] && out_rdy[g] && q.size() != 0) begin
          void'(q.pop_front());
          popped++;
        end
        if (flush[g]) q.delete();
        else if (in_vld[g] && in_rdy[g]) q.push_back(in_dat[g]);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int acc, k, sent, base;
    logic fire;
    in_vld = '0; out_rdy = '0; flush = '0; in_dat[0] = '0; in_dat[1] = '0;
    z_in.valid = 1'b0; z_in.data = '0; z_out.ready = 1'b0; z_flush = 1'b0;
    rst = 1'b1;
    #2;
    check("rst out_vld", out_vld[0], 1'b0);
    check("rst busy", busy[0], 1'b0);
    check("rst in_rdy", in_rdy[0], 1'b1);
    check("rst out_dat", out_dat[0], 32'hDEAD_BEEF);
    check("rst out_dat l1", out_dat[1], 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Back-to-back stream through DEPTH 3: first out on 4th negedge, then no bubbles.
    out_rdy[0] = 1'b1; in_vld[0] = 1'b1; in_dat[0] = 32'd1;
    for (int n = 1; n <= 19; n++) begin
      @(negedge clk);
      if (n <= 16) check("t1 in_rdy", in_rdy[0], 1'b1);
      if (n == 3) check("t1 latency", out_vld[0], 1'b0);
      if (n >= 4) begin
        check("t1 out_vld", out_vld[0], 1'b1);
        check("t1 out_dat", out_dat[0], n - 3);
      end
      @(posedge clk); #1;
      if (in_dat[0] < 32'd16) in_dat[0]++;
      else in_vld[0] = 1'b0;
    end

    // Stalled DEPTH 2 holds exactly four items.
    out_rdy[1] = 1'b0; in_vld[1] = 1'b1; in_dat[1] = 32'hA0; acc = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      fire = in_vld[1] && in_rdy[1];
      if (fire) acc++;
      @(posedge clk); #1;
      if (fire) in_dat[1]++;
    end
    check("t2 accepted", acc, 4);
    check("t2 in_rdy", in_rdy[1], 1'b0);
    out_rdy[1] = 1'b1; k = 0;
    for (int n = 0; n < 20 && k < 6; n++) begin
      @(negedge clk);
      if (out_vld[1]) begin
        check("t2 order", out_dat[1], 32'hA0 + k);
        k++;
      end
      fire = in_vld[1] && in_rdy[1];
      @(posedge clk); #1;
      if (fire) in_dat[1]++;
    end
    check("t2 drained", k, 6);
    in_vld[1] = 1'b0;
    repeat (6) @(posedge clk);
    #1;

    // Random valid/ready traffic, 1000 items.
    base = g_chk[1].popped; sent = 0;
    for (int n = 0; n < 20000 && sent < 1000; n++) begin
      @(negedge clk);
      fire = in_vld[1] && in_rdy[1];
      if (fire) sent++;
      @(posedge clk); #1;
      out_rdy[1] = 1'($urandom_range(0, 1));
      if (!in_vld[1] || fire) begin
        in_vld[1] = (sent < 1000) && ($urandom_range(0, 1) == 1);
        in_dat[1] = $urandom;
      end
    end
    in_vld[1] = 1'b0; out_rdy[1] = 1'b1;
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("t3 sent", sent, 1000);
    check("t3 delivered", g_chk[1].popped - base, 1000);
    check("t3 idle", busy[1], 1'b0);

    // Flush with three in flight; 0x55 offered in the flush cycle must vanish.
    @(posedge clk); #1;
    out_rdy[0] = 1'b0; in_vld[0] = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      in_dat[0] = 32'h11 * i;
      @(posedge clk); #1;
    end
    check("t4 busy before", busy[0], 1'b1);
    flush[0] = 1'b1; in_dat[0] = 32'h55;
    @(posedge clk); #1;
    flush[0] = 1'b0; in_vld[0] = 1'b0; out_rdy[0] = 1'b1;
    @(negedge clk);
    check("t4 out_vld", out_vld[0], 1'b0);
    check("t4 busy", busy[0], 1'b0);
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      check("t4 quiet", out_vld[0], 1'b0);
    end

    // Asynchronous reset with five entries held.
    @(posedge clk); #1;
    out_rdy[0] = 1'b0; in_vld[0] = 1'b1; in_dat[0] = 32'h100; acc = 0;
    for (int n = 0; n < 20 && acc < 5; n++) begin
      @(negedge clk);
      fire = in_vld[0] && in_rdy[0];
      if (fire) acc++;
      @(posedge clk); #1;
      if (fire) in_dat[0]++;
    end
    in_vld[0] = 1'b0;
    check("t5 accepted", acc, 5);
    @(negedge clk);
    check("t5 held out_vld", out_vld[0], 1'b1);
    #3 rst = 1'b1;
    #1;
    check("t5 out_vld", out_vld[0], 1'b0);
    check("t5 busy", busy[0], 1'b0);
    check("t5 in_rdy", in_rdy[0], 1'b1);
    check("t5 out_dat", out_dat[0], 32'hDEAD_BEEF);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0; out_rdy[0] = 1'b1; in_vld[0] = 1'b1; in_dat[0] = 32'h77;
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      if (n == 4) begin
        check("t5 post out_vld", out_vld[0], 1'b1);
        check("t5 post out_dat", out_dat[0], 32'h77);
      end
      @(posedge clk); #1;
      in_vld[0] = 1'b0;
    end

    // DEPTH 0 is a wire; flush has no effect.
    z_flush = 1'b1;
    for (int i = 0; i < 4; i++) begin
      z_in.valid = i[0]; z_out.ready = i[1]; z_in.data = $urandom;
      #1;
      check("z out_vld", z_out.valid, i[0]);
      check("z in_rdy", z_in.ready, i[1]);
      check("z out_dat", z_out.data, z_in.data);
      check("z busy", z_busy, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/gnrl_pipe_stages.md
Name: gnrl_pipe_stages

Overview:
- Parametrised elastic pipeline of DEPTH register stages with valid/ready handshake on both ends.
- Generalises the plain load-enable DFFs: backpressure, full throughput, synchronous flush, configurable reset value.
- Sits between core pipeline units (IF/ID/EX/MEM/WB boundaries, bus request/response paths) so each boundary can stall without a combinational ready chain.

Parameters:
- DW, 32, payload width in bits (>=1).
- DEPTH, 1, number of register stages (0..8); 0 = combinational pass-through.
- RST_VAL, {DW{1'b0}}, reset value of every data register.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous flush; drops all held entries.
- in_valid  input  1  upstream has payload.
- in_ready  output  1  stage 0 can accept; registered, never combinationally dependent on out_ready (DEPTH>=1).
- in_data  input  DW  upstream payload.
- out_valid  output  1  last stage holds payload.
- out_ready  input  1  downstream accepts.
- out_data  output  DW  last-stage payload.
- busy  output  1  OR of all valid bits (main and skid, all stages).

Behaviour:
- Each stage is a 2-entry skid buffer: main reg (m_vld, m_dat) and skid reg (s_vld, s_dat).
- Stage k input is stage k-1 output; stage 0 input is in_*; out_* is stage DEPTH-1 main reg.
- Stage ready to its upstream = !s_vld (registered).
- Fire definitions: in_fire = valid & ready on the stage's upstream; out_fire = m_vld & downstream ready.
- Per-stage update when flush=0:
  - m_vld=0 or out_fire: main loads skid if s_vld (s_vld<=0), else loads input if in_fire, else m_vld<=0.
  - m_vld=1, no out_fire, in_fire: input captured into skid (s_vld<=1).
  - Otherwise hold.
  - Simultaneous in_fire and out_fire with s_vld=1: main<=skid, skid<=input, s_vld stays 1.
- Latency: in_fire at edge N -> out_valid visible after edge N+DEPTH-1 (one register per stage, first visible cycle after DEPTH edges) when unstalled.
- Throughput: 1 item/cycle sustained with out_ready=1; no bubbles.
- Capacity: 2*DEPTH entries; in_ready falls one cycle after stage 0 skid fills.
- Order preserved; no drop or duplication except on flush.
- Flush: all m_vld/s_vld <= 0 at the edge; in_fire in the flush cycle is discarded; out_fire in the flush cycle still counts as delivered. Data regs keep old values.
- Data regs load only on capture (load-enable); no clearing on idle, unlike the plain DFF cells.
- out_data with out_valid=0 is stale; consumers must not sample it.
- Reset (any time, incl. mid-transfer): all valid bits 0, all data regs RST_VAL; out_valid=0, busy=0, in_ready=1 one cycle... immediately (in_ready = !s_vld = 1 during reset). Post-reset first edge behaves as empty pipe.
- DEPTH=0: out_valid=in_valid, in_ready=out_ready, out_data=in_data, busy=0; flush ignored.

Optional Feature:
- Macro GNRL_PIPE_XCHECK_EN.
- Defined (simulation only, excluded under FPGA_SOURCE): when rst=0, checks at every rising clk that in_valid, out_ready, flush are not X, and that in_data is not X while in_valid=1; violation -> $fatal with stage-pipe instance name. Also asserts in_data stable while in_valid=1 and in_ready=0.
- Undefined: no checks; RTL behaviour identical.

Test Plan:
- DEPTH=3, DW=32, out_ready=1, push 0x1..0x10 back-to-back -> 0x1 out 3 cycles after first accept, then one item/cycle, in_ready constantly 1.
- DEPTH=2, out_ready=0, push continuously -> exactly 4 items accepted (0xA0..0xA3), in_ready=0 from the cycle after the 4th; raise out_ready -> 0xA0..0xA3 in order, then new items flow.
- DEPTH=2, random in_valid/out_ready (50%), 1000 items -> scoreboard in-order, zero loss/duplication.
- DEPTH=3, 3 entries in flight, flush=1 with in_valid=1 data 0x55 -> next cycle out_valid=0, busy=0, 0x55 never appears at output.
- RST_VAL=32'hDEAD_BEEF, assert rst mid-stream with 5 entries held -> out_valid=0, busy=0, in_ready=1 immediately, out_data=0xDEADBEEF; after release pipe accepts normally.
- DEPTH=0 -> out_* follow in_* combinationally, in_ready=out_ready, busy=0.
